// File: rtl/tof_bram_write_arbiter_pkg.sv
// tof_arb_pkg: shared types and default sizing for the ToF BRAM write arbiter
package tof_arb_pkg;
    localparam int N_SENSORS = 8;
    localparam int IDX_W = 3;
    localparam int ZONES = 64;
    localparam int ZONE_W = $clog2(ZONES);
    typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_t;
endpackage

// File: rtl/tof_bram_write_arbiter_if.sv
// tof_bram_write_arbiter_if: sensor request / BRAM write control bundle
interface tof_bram_write_arbiter_if #(
    parameter int N_SENSORS = 8,
    parameter int IDX_W = 3
);
    logic [N_SENSORS-1:0] ToF_dr;
    logic [N_SENSORS-1:0] sensor_en;
    logic                 frame_ack;
    logic [IDX_W-1:0]     ToF_Index;
    logic [N_SENSORS-1:0] ack;
    logic                 wea;
    logic                 all_data_written;
    logic                 busy;
    modport master (
        output ToF_dr, sensor_en, frame_ack,
        input  ToF_Index, ack, wea, all_data_written, busy
    );
    modport slave (
        input  ToF_dr, sensor_en, frame_ack,
        output ToF_Index, ack, wea, all_data_written, busy
    );
endinterface

// File: rtl/tof_bram_write_arbiter_rr_pick.sv
// rr_pick: first set request at or after i_start, searching upward with wrap
module rr_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_start,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);
    // scan from farthest to nearest so the nearest request wins
    always_comb begin
        o_valid = 1'b0;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(i_start) + i;
            if (j >= N) j = j - N;
            if (i_req[j]) begin
                o_valid = 1'b1;
                o_idx = W'(j);
            end
        end
    end
endmodule

// File: rtl/tof_bram_write_arbiter.sv
// tof_bram_write_arbiter: round-robin sharing of the ToF BRAM write port with frame tracking
module tof_bram_write_arbiter
    import tof_arb_pkg::*;
#(
    parameter int N_SENSORS = tof_arb_pkg::N_SENSORS,
    parameter int IDX_W = tof_arb_pkg::IDX_W,
    parameter int ZONES = tof_arb_pkg::ZONES,
    parameter int SETTLE_CYCLES = 1
) (
    input logic clk,
    input logic reset,
    tof_bram_write_arbiter_if.slave bus
);
    localparam int ZW = $clog2(ZONES);

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_settle;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_last;
    logic [IDX_W-1:0]     w_start;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_valid;
    logic [N_SENSORS-1:0] r_done;
    logic [N_SENSORS-1:0] w_elig;
    logic [ZW-1:0]        r_cnt [N_SENSORS];
    logic                 r_adw;
    logic                 w_write;
    logic                 w_clear;
    logic                 w_complete;
    logic                 w_grant;

    assign w_elig = bus.ToF_dr & bus.sensor_en & ~r_done;
    assign w_start = (r_last == IDX_W'(N_SENSORS - 1)) ? '0 : r_last + IDX_W'(1);
    assign w_write = r_state == WRITE;
    assign w_clear = bus.frame_ack & r_adw;
    assign w_complete = (bus.sensor_en != '0) && ((r_done & bus.sensor_en) == bus.sensor_en);
    assign w_grant = (r_state == IDLE) && !r_adw && w_valid;

    rr_pick #(.N(N_SENSORS), .W(IDX_W)) u_pick (
        .i_req(w_elig),
        .i_start(w_start),
        .o_valid(w_valid),
        .o_idx(w_pick)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    // next state and write strobes; strobes vanish at once on reset since state is IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = SETTLE;
            SETTLE:  if (r_settle == 2'(SETTLE_CYCLES - 1)) w_next = WRITE;
            WRITE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
        bus.wea = w_write;
        bus.ack = w_write ? (N_SENSORS'(1) << r_idx) : '0;
        bus.busy = r_state != IDLE;
        bus.ToF_Index = r_idx;
        bus.all_data_written = r_adw;
    end

    // grant index, settle timer and round-robin pointer (sensor 0 first after reset)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_settle <= '0;
            r_last <= IDX_W'(N_SENSORS - 1);
        end else begin
            if (w_grant) r_idx <= w_pick;
            r_settle <= (r_state == SETTLE) ? r_settle + 2'd1 : 2'd0;
            if (w_write) r_last <= r_idx;
        end
    end

    // zone counters, done mask and frame-complete flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= '0;
            r_adw <= 1'b0;
            for (int i = 0; i < N_SENSORS; i++) r_cnt[i] <= '0;
        end else begin
            r_adw <= w_clear ? 1'b0 : (r_adw | w_complete);
            if (w_clear) begin
                r_done <= '0;
                for (int i = 0; i < N_SENSORS; i++) r_cnt[i] <= '0;
            end
            if (w_write) begin
                if (r_cnt[r_idx] == ZW'(ZONES - 1)) begin
                    r_cnt[r_idx] <= '0;
                    r_done[r_idx] <= 1'b1;
                end else begin
                    r_cnt[r_idx] <= r_cnt[r_idx] + ZW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_tof_bram_write_arbiter.sv
// tb_tof_bram_write_arbiter: directed table plus corner-case sequences for the ToF write arbiter
module tb_tof_bram_write_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tof_bram_write_arbiter_if #(.N_SENSORS(8), .IDX_W(3)) bus ();

    tof_bram_write_arbiter dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {
        logic [7:0] dr;
        logic [7:0] en;
        logic       valid;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wea", 32'(bus.wea), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_idx", 32'(bus.ToF_Index), 0);
        chk("rst_adw", 32'(bus.all_data_written), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic xfer(input logic [7:0] dr, input logic [7:0] en, output logic got,
                        output logic [2:0] idx, output logic [7:0] a, output int lat);
        bus.ToF_dr = dr;
        bus.sensor_en = en;
        got = 1'b0;
        idx = '0;
        a = '0;
        lat = 0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (bus.wea) begin
                got = 1'b1;
                idx = bus.ToF_Index;
                a = bus.ack;
                lat = n;
            end
        end
        if (got) begin
            @(posedge clk);
            #1;
        end
        bus.ToF_dr = '0;
    endtask

    task automatic pulse_ack();
        bus.frame_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ack = 1'b0;
    endtask

    initial begin
        logic       got;
        logic [2:0] idx;
        logic [7:0] a;
        int         lat;
        int         cnt;
        int         prev;
        int         bad;
        bus.ToF_dr = '0;
        bus.sensor_en = '0;
        bus.frame_ack = 1'b0;

        tbl[0]  = '{8'h01, 8'hFF, 1'b1, 3'd0};
        tbl[1]  = '{8'h01, 8'hFF, 1'b1, 3'd0};
        tbl[2]  = '{8'h81, 8'hFF, 1'b1, 3'd7};
        tbl[3]  = '{8'h81, 8'hFF, 1'b1, 3'd0};
        tbl[4]  = '{8'h06, 8'hFF, 1'b1, 3'd1};
        tbl[5]  = '{8'h06, 8'hFF, 1'b1, 3'd2};
        tbl[6]  = '{8'hF0, 8'h0F, 1'b0, 3'd0};
        tbl[7]  = '{8'hF0, 8'h30, 1'b1, 3'd4};
        tbl[8]  = '{8'hF0, 8'hFF, 1'b1, 3'd5};
        tbl[9]  = '{8'h18, 8'hFF, 1'b1, 3'd3};
        tbl[10] = '{8'hFF, 8'hFE, 1'b1, 3'd4};

        do_reset();
        for (int v = 0; v < 11; v++) begin
            xfer(tbl[v].dr, tbl[v].en, got, idx, a, lat);
            chk($sformatf("tbl%0d_grant", v), 32'(got), 32'(tbl[v].valid));
            if (tbl[v].valid) begin
                chk($sformatf("tbl%0d_idx", v), 32'(idx), 32'(tbl[v].idx));
                chk($sformatf("tbl%0d_ack", v), 32'(a), 32'(8'h01 << tbl[v].idx));
                chk($sformatf("tbl%0d_lat", v), 32'(lat), 2);
            end
        end

        // single sensor frame, with an ignored frame_ack part way through
        do_reset();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            if (k == 30) begin
                pulse_ack();
                chk("early_ack_adw", 32'(bus.all_data_written), 0);
            end
            xfer(8'h01, 8'h01, got, idx, a, lat);
            if (!got || idx != 3'd0 || a != 8'h01 || lat != 2) bad++;
            if (k == 62) chk("s1_adw_before", 32'(bus.all_data_written), 0);
        end
        chk("s1_64_writes", 32'(bad), 0);
        @(posedge clk);
        #1;
        chk("s1_adw_set", 32'(bus.all_data_written), 1);
        xfer(8'h01, 8'h01, got, idx, a, lat);
        chk("s1_no_grant_when_full", 32'(got), 0);
        chk("s1_adw_hold", 32'(bus.all_data_written), 1);
        pulse_ack();
        chk("s1_adw_cleared", 32'(bus.all_data_written), 0);
        xfer(8'h01, 8'h01, got, idx, a, lat);
        chk("s1_regrant", 32'(got), 1);
        chk("s1_regrant_idx", 32'(idx), 0);

        // all eight sensors continuously requesting
        do_reset();
        bus.sensor_en = 8'hFF;
        bus.ToF_dr = 8'hFF;
        cnt = 0;
        prev = 0;
        for (int c = 0; c < 1700 && cnt < 512; c++) begin
            @(posedge clk);
            #1;
            if (bus.wea) begin
                chk("rr_idx", 32'(bus.ToF_Index), 32'(cnt % 8));
                chk("rr_ack", 32'(bus.ack), 32'(8'h01 << (cnt % 8)));
                if (cnt > 0) chk("rr_spacing", 32'(c - prev), 3);
                prev = c;
                cnt++;
            end
        end
        chk("rr_write_count", 32'(cnt), 512);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rr_adw_set", 32'(bus.all_data_written), 1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.wea) bad++;
        end
        chk("rr_idle_when_full", 32'(bad), 0);
        pulse_ack();
        chk("rr_adw_cleared", 32'(bus.all_data_written), 0);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(posedge clk);
            #1;
            if (bus.wea) begin
                got = 1'b1;
                idx = bus.ToF_Index;
            end
        end
        chk("rr_after_ack_grant", 32'(got), 1);
        chk("rr_after_ack_idx", 32'(idx), 0);
        bus.ToF_dr = '0;
        @(posedge clk);
        #1;

        // done sensor keeps requesting but receives no ack until frame_ack
        do_reset();
        bad = 0;
        for (int k = 0; k < 64; k++) begin
            xfer(8'h04, 8'h0C, got, idx, a, lat);
            if (!got || idx != 3'd2) bad++;
        end
        chk("s2_64_writes", 32'(bad), 0);
        chk("s2_adw_low", 32'(bus.all_data_written), 0);
        xfer(8'h04, 8'h0C, got, idx, a, lat);
        chk("s2_done_no_ack", 32'(got), 0);
        xfer(8'h0C, 8'h0C, got, idx, a, lat);
        chk("s2_other_grant", 32'(got), 1);
        chk("s2_other_idx", 32'(idx), 3);
        bus.sensor_en = 8'h04;
        @(posedge clk);
        #1;
        chk("s2_adw_set", 32'(bus.all_data_written), 1);
        pulse_ack();
        chk("s2_adw_cleared", 32'(bus.all_data_written), 0);
        xfer(8'h04, 8'h04, got, idx, a, lat);
        chk("s2_regrant", 32'(got), 1);
        chk("s2_regrant_ack", 32'(a), 32'h04);

        // asynchronous reset in the middle of SETTLE
        do_reset();
        bus.sensor_en = 8'hFF;
        bus.ToF_dr = 8'h20;
        @(posedge clk);
        #1;
        chk("ar_settle_idx", 32'(bus.ToF_Index), 5);
        chk("ar_settle_busy", 32'(bus.busy), 1);
        chk("ar_settle_wea", 32'(bus.wea), 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_idx", 32'(bus.ToF_Index), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_wea", 32'(bus.wea), 0);
        chk("ar_ack", 32'(bus.ack), 0);
        @(posedge clk);
        #1;
        chk("ar_hold_wea", 32'(bus.wea), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        xfer(8'h28, 8'hFF, got, idx, a, lat);
        chk("ar_first_grant", 32'(got), 1);
        chk("ar_first_idx", 32'(idx), 3);

        // disabling an unfinished sensor completes the frame
        do_reset();
        for (int k = 0; k < 64; k++) xfer(8'h01, 8'h03, got, idx, a, lat);
        for (int k = 0; k < 10; k++) xfer(8'h02, 8'h03, got, idx, a, lat);
        chk("en_adw_low", 32'(bus.all_data_written), 0);
        bus.sensor_en = 8'h01;
        @(posedge clk);
        #1;
        chk("en_adw_set", 32'(bus.all_data_written), 1);
        bus.sensor_en = 8'h00;
        pulse_ack();
        repeat (3) @(posedge clk);
        #1;
        chk("en_zero_no_frame", 32'(bus.all_data_written), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
